// File: rtl/descrypt_core_output_pkg.sv
// rtl/descrypt_core_output_pkg.sv - field widths, packed record layout and parser states
package descrypt_core_output_pkg;

  localparam int NUM_BATCHES_MSB = 0;
  localparam int NUM_PKTS_MSB    = 1;
  localparam int RAM_ADDR_MSB    = 11;

  localparam int BATCH_W = NUM_BATCHES_MSB + 1;
  localparam int PKT_W   = NUM_PKTS_MSB + 1;
  localparam int ADDR_W  = RAM_ADDR_MSB + 1;

  // Record layout, LSB first: hash_addr, key_idx, batch_complete, equal, key_valid, pkt, batch
  localparam int REC_ADDR_LSB  = 0;
  localparam int REC_IDX_LSB   = REC_ADDR_LSB + ADDR_W;
  localparam int REC_BC_BIT    = REC_IDX_LSB + 4;
  localparam int REC_EQ_BIT    = REC_BC_BIT + 1;
  localparam int REC_KV_BIT    = REC_EQ_BIT + 1;
  localparam int REC_PKT_LSB   = REC_KV_BIT + 1;
  localparam int REC_BATCH_LSB = REC_PKT_LSB + PKT_W;
  localparam int OUT_REC_MSB   = REC_BATCH_LSB + BATCH_W - 1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    IDX,
    A0,
    A1,
    A2
  } parse_state_e;

endpackage

// File: rtl/descrypt_out_fifo.sv
// rtl/descrypt_out_fifo.sv - synchronous first-word-fall-through record FIFO
module descrypt_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = rd_en_i && !empty_o;
  // A push into a full FIFO is accepted when the head leaves in the same cycle
  assign do_push = wr_en_i && (!full_o || do_pop);

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/descrypt_core_output.sv
// rtl/descrypt_core_output.sv - nibble stream parser, record FIFO and dout_ready back-pressure
module descrypt_core_output
  import descrypt_core_output_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic [3:0]                din,
  output logic                      dout_ready,
  output logic                      empty,
  input  logic                      rd_en,
  output logic [NUM_BATCHES_MSB:0]  rec_batch_num,
  output logic [NUM_PKTS_MSB:0]     rec_pkt_num,
  output logic                      rec_key_valid,
  output logic                      rec_equal,
  output logic                      rec_batch_complete,
  output logic [3:0]                rec_key_idx,
  output logic [RAM_ADDR_MSB:0]     rec_hash_addr,
  output logic                      err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  // The core samples dout_ready through a register and may launch one more record
  // after it falls; the limit keeps a slot for that record and the one being parsed.
  localparam logic [CNT_W:0] READY_LIMIT = (CNT_W+1)'(FIFO_DEPTH - 2);

  parse_state_e          state_q;
  logic [OUT_REC_MSB:0]  rec_q;
  logic                  push_q;
  logic                  err_q;
  logic                  dout_ready_q;
  logic                  dout_ready_d;
  logic                  busy;
  logic [CNT_W:0]        pending;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [OUT_REC_MSB:0]  head_rec;
  logic                  overflow;

  assign busy         = (state_q != IDLE) || push_q;
  assign pending      = {1'b0, fifo_count} + {{CNT_W{1'b0}}, busy};
  assign dout_ready_d = (pending < READY_LIMIT);
  assign overflow     = push_q && fifo_full && !(rd_en && !fifo_empty);

  always_ff @(posedge CLK) begin
    push_q <= 1'b0;
    if (rst) begin
      state_q      <= IDLE;
      rec_q        <= '0;
      err_q        <= 1'b0;
      dout_ready_q <= 1'b0;
    end else begin
      dout_ready_q <= dout_ready_d;
      if (overflow) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (din[0]) begin
            rec_q                              <= '0;
            rec_q[REC_PKT_LSB +: PKT_W]        <= din[PKT_W:1];
            rec_q[REC_BATCH_LSB +: BATCH_W]    <= din[PKT_W+BATCH_W:PKT_W+1];
            state_q                            <= HDR;
          end
        end
        HDR: begin
          if (din[3] || (din[1:0] == 2'b00)) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            rec_q[REC_KV_BIT] <= din[2];
            rec_q[REC_EQ_BIT] <= din[1];
            rec_q[REC_BC_BIT] <= din[0];
            if (din[1]) begin
              state_q <= IDX;
            end else begin
              push_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        IDX: begin
          rec_q[REC_IDX_LSB +: 4] <= din;
          state_q                 <= A0;
        end
        A0: begin
          rec_q[REC_ADDR_LSB +: 4] <= din;
          state_q                  <= A1;
        end
        A1: begin
          rec_q[REC_ADDR_LSB+4 +: 4] <= din;
          state_q                    <= A2;
        end
        A2: begin
          rec_q[REC_ADDR_LSB+8 +: ADDR_W-8] <= din[ADDR_W-9:0];
          push_q                            <= 1'b1;
          state_q                           <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  descrypt_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_REC_MSB + 1)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_i     (rst),
    .wr_en_i   (push_q),
    .wr_data_i (rec_q),
    .rd_en_i   (rd_en),
    .rd_data_o (head_rec),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign dout_ready         = dout_ready_q;
  assign empty              = fifo_empty;
  assign err                = err_q;
  assign rec_batch_num      = head_rec[REC_BATCH_LSB +: BATCH_W];
  assign rec_pkt_num        = head_rec[REC_PKT_LSB +: PKT_W];
  assign rec_key_valid      = head_rec[REC_KV_BIT];
  assign rec_equal          = head_rec[REC_EQ_BIT];
  assign rec_batch_complete = head_rec[REC_BC_BIT];
  assign rec_key_idx        = head_rec[REC_IDX_LSB +: 4];
  assign rec_hash_addr      = head_rec[REC_ADDR_LSB +: ADDR_W];

endmodule
